mem_access_unit: RTL

- Initiator side of the data memory interface: accepts load/store requests from the CPU MEM stage and drives the word-addressed data memory's rd_wr/endereco/entrada lines.
- Returns load data from the memory's registered saida output.
- Handles byte and halfword accesses: sub-word loads use lane extraction with sign or zero extension; sub-word stores use a read-modify-write sequence.
- Flags misaligned requests without touching memory.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU MEM-stage initiator for a word-addressed data memory
//
// Purpose: accepts load/store requests, drives the data memory's rd_wr /
// endereco / entrada lines and returns load data taken from the memory's
// registered saida output. Byte and halfword loads select a lane and
// sign/zero extend it; byte and halfword stores do a read-modify-write.
// Misaligned requests and size 11 return resp_err without touching memory.
//
// Optional feature macro: MEM_ACCESS_COUNT_EN adds saturating load, store and
// error counters (ld_count, st_count, err_count).
//
// Ports:
//   Clk, Rst_n               clock (rising edge), synchronous active-low reset
//   req_valid / req_ready    request handshake; req_ready is high only in IDLE
//   req_we                   0 load, 1 store
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             zero-extend sub-word loads
//   req_addr                 byte address (little-endian lanes)
//   req_wdata                store data, right-aligned
//   resp_valid               one-cycle completion pulse
//   resp_rdata               load result (0 for stores and errors)
//   resp_err                 misaligned or illegal size
//   mem_rd_wr                memory strobe: 0 read, 1 write
//   mem_endereco             memory word address
//   mem_entrada              memory write data
//   mem_saida                memory read data, one-cycle latency
//   ld_count, st_count, err_count   statistics (MEM_ACCESS_COUNT_EN only)

module mem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [31:0]       mem_entrada,
`ifdef MEM_ACCESS_COUNT_EN
  output logic [CNT_W-1:0]  ld_count,
  output logic [CNT_W-1:0]  st_count,
  output logic [CNT_W-1:0]  err_count,
`endif
  input  logic [31:0]       mem_saida
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        req_fire;
  logic        req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_ready = (state == S_IDLE);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction and extension for loads; mem_saida is valid in DATA.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0: byte_sel = mem_saida[7:0];
      2'd1: byte_sel = mem_saida[15:8];
      2'd2: byte_sel = mem_saida[23:16];
      default: byte_sel = mem_saida[31:24];
    endcase
    half_sel = lane_q[1] ? mem_saida[31:16] : mem_saida[15:0];
    load_val = mem_saida;
    case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = uns_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_saida;
    endcase
  end

  // Merge the store data into the word just read for sub-word stores.
  always_comb begin
    merged = mem_saida;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
      mem_rd_wr    <= 1'b0;
      mem_endereco <= '0;
      mem_entrada  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_bad) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state        <= S_WR;
              mem_rd_wr    <= 1'b1;
              mem_endereco <= req_addr[ADDR_W+1:2];
              mem_entrada  <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state        <= S_RD;
              mem_rd_wr    <= 1'b0;
              mem_endereco <= req_addr[ADDR_W+1:2];
            end
          end
        end
        S_RD: state <= S_DATA;
        S_DATA: begin
          if (we_q) begin
            state       <= S_WR;
            mem_rd_wr   <= 1'b1;
            mem_entrada <= merged;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        S_WR: begin
          // The memory samples the write on the edge that leaves WR.
          state      <= S_RESP;
          mem_rd_wr  <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: begin
          state     <= S_IDLE;
          mem_rd_wr <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Counters advance at the end of the resp_valid cycle and stick at all-ones.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ld_count  <= '0;
      st_count  <= '0;
      err_count <= '0;
    end else if (state == S_RESP) begin
      if (resp_err) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end else if (we_q) begin
        if (st_count != '1) st_count <= st_count + CNT_W'(1);
      end else begin
        if (ld_count != '1) ld_count <= ld_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule
